// File: rtl/branch_predictor_bht_pkg.sv
// Shared definitions for the BHT/BTB branch predictor: direction-counter encodings
// and the PC index/tag slicing used by the pipeline and the bench alike.
package branch_predictor_bht_pkg;

  // Weakly-not-taken, weakly-taken and strongly-taken encodings for a counter of 'bits' width.
  function automatic int ctr_wnt(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int ctr_wt(input int bits);
    return 1 << (bits - 1);
  endfunction

  function automatic int ctr_strong(input int bits);
    return (1 << bits) - 1;
  endfunction

  // idx = pc[idx_w+1:2], tag = pc[idx_w+tag_bits+1:idx_w+2]
  function automatic logic [31:0] pc_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w, input int tag_bits);
    return (pc >> (idx_w + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter.sv
// Saturating up/down counter with synchronous reset value, clear and load.
// Priority: rst > clr > load > inc/dec; inc and dec hold at all-ones and zero.
module branch_predictor_bht_sat_counter #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end else if (dec && (q != '0)) begin
      q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped tagged branch history table + target buffer, queried combinationally
// in IF and trained from EX, with saturating branch/mispredict statistics.
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  // upd_en is a single-cycle strobe per resolved instruction; there is no ready,
  // the table always accepts, and upd_* / upd_mispredict are ignored while it is low.
  input  logic              upd_en,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispredict,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_HI = IDX_W + TAG_BITS + 1;
  localparam logic [CTR_BITS-1:0] WNT    = CTR_BITS'(ctr_wnt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WT     = CTR_BITS'(ctr_wt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] STRONG = CTR_BITS'(ctr_strong(CTR_BITS));

  logic [ENTRIES-1:0]  valid;
  logic [ENTRIES-1:0]  jump_mem;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [XLEN-1:0]     target_mem [ENTRIES];
  logic [CTR_BITS-1:0] ctr        [ENTRIES];

  logic [IDX_W-1:0]    pidx, upd_idx;
  logic [TAG_BITS-1:0] ptag, upd_tag;
  logic                upd_hit, train, alloc;
  logic [CTR_BITS-1:0] alloc_ctr;
  logic                unused_pc_bits;

  assign pidx    = pred_pc[IDX_W+1:2];
  assign ptag    = pred_pc[TAG_HI:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[TAG_HI:IDX_W+2];
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  // Prediction reads pre-update state, so a same-cycle update to this index is not bypassed.
  assign pred_hit    = valid[pidx] && (tag_mem[pidx] == ptag);
  assign pred_taken  = pred_hit && (jump_mem[pidx] || ctr[pidx][CTR_BITS-1]);
  assign pred_target = pred_taken ? target_mem[pidx] : pred_pc + XLEN'(4);

  assign upd_hit   = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign train     = upd_en && upd_hit;
  assign alloc     = upd_en && !upd_hit && upd_taken;
  assign alloc_ctr = upd_is_jump ? STRONG : WT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= '0;
    end else if (alloc) begin
      valid[upd_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: nothing reads them while the valid bit is clear.
  always_ff @(posedge CLK) begin
    if (!RESET && (alloc || (train && upd_taken))) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= upd_target;
      jump_mem[upd_idx]   <= upd_is_jump;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = (upd_idx == IDX_W'(i));

    branch_predictor_bht_sat_counter #(.W(CTR_BITS), .RST_VAL(WNT)) u_ctr (
      .clk      (CLK),
      .rst      (RESET),
      .clr      (1'b0),
      .load     (alloc && sel),
      .load_val (alloc_ctr),
      .inc      (train && sel && upd_taken),
      .dec      (train && sel && !upd_taken),
      .q        (ctr[i])
    );
  end

  branch_predictor_bht_sat_counter #(.W(STAT_W), .RST_VAL(STAT_W'(0))) u_stat_br (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (stat_clr),
    .load     (1'b0),
    .load_val (STAT_W'(0)),
    .inc      (upd_en),
    .dec      (1'b0),
    .q        (stat_branches)
  );

  branch_predictor_bht_sat_counter #(.W(STAT_W), .RST_VAL(STAT_W'(0))) u_stat_mp (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (stat_clr),
    .load     (1'b0),
    .load_val (STAT_W'(0)),
    .inc      (upd_en && upd_mispredict),
    .dec      (1'b0),
    .q        (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: drivers queue hand-computed expectations,
// a negedge monitor pops and compares them against a default and a STAT_W=4 instance.
module tb_branch_predictor_bht;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] pred_pc;
  logic        upd_en, upd_is_jump, upd_taken, upd_mispredict, stat_clr;
  logic [31:0] upd_pc, upd_target;

  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [31:0] stat_branches, stat_mispredicts;

  logic        h4, t4;
  logic [31:0] tg4;
  logic [3:0]  s4_br, s4_mp;

  always #5 CLK = ~CLK;

  branch_predictor_bht dut (
    .CLK(CLK), .RESET(RESET), .pred_pc(pred_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .stat_clr(stat_clr),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor_bht #(.STAT_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .pred_pc(pred_pc),
    .pred_hit(h4), .pred_taken(t4), .pred_target(tg4),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .stat_clr(stat_clr),
    .stat_branches(s4_br), .stat_mispredicts(s4_mp)
  );

  // scoreboard
  logic [33:0] exp_q[$];
  string       name_q[$];
  logic [71:0] stat_q[$];
  string       stat_name_q[$];
  logic        pred_chk = 1'b0;
  logic        stat_chk = 1'b0;
  logic        end_chk  = 1'b0;
  int          n_cmp    = 0;
  int          n_fail   = 0;
  logic [33:0] e_pred;
  logic [71:0] e_stat;
  string       e_name;

  always @(negedge CLK) begin
    if (pred_chk) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pred: no expectation queued, got hit=%0b taken=%0b target=%h",
                 pred_hit, pred_taken, pred_target);
      end else begin
        e_pred = exp_q.pop_front();
        e_name = name_q.pop_front();
        if ({pred_hit, pred_taken, pred_target} !== e_pred) begin
          n_fail++;
          $display("FAIL %s: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                   e_name, pred_hit, pred_taken, pred_target, e_pred[33], e_pred[32], e_pred[31:0]);
        end
      end
    end
    if (stat_chk) begin
      n_cmp++;
      if (stat_q.size() == 0) begin
        n_fail++;
        $display("FAIL stats: no expectation queued, got %0d/%0d", stat_branches, stat_mispredicts);
      end else begin
        e_stat = stat_q.pop_front();
        e_name = stat_name_q.pop_front();
        if ({stat_branches, stat_mispredicts, s4_br, s4_mp} !== e_stat) begin
          n_fail++;
          $display("FAIL %s: got br=%0d mp=%0d br4=%0d mp4=%0d, want br=%0d mp=%0d br4=%0d mp4=%0d",
                   e_name, stat_branches, stat_mispredicts, s4_br, s4_mp,
                   e_stat[71:40], e_stat[39:8], e_stat[7:4], e_stat[3:0]);
        end
      end
    end
    if (end_chk) begin
      n_cmp++;
      if ((exp_q.size() != 0) || (stat_q.size() != 0)) begin
        n_fail++;
        $display("FAIL drain: %0d pred and %0d stat expectations left, want 0 and 0",
                 exp_q.size(), stat_q.size());
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge CLK);
    #1;
    RESET = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0; stat_clr = 1'b0;
    pred_chk = 1'b0; stat_chk = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic jump, input logic taken,
                     input logic [31:0] tgt, input logic mis);
    upd_en = 1'b1; upd_pc = pc; upd_is_jump = jump; upd_taken = taken;
    upd_target = tgt; upd_mispredict = mis;
  endtask

  task automatic query(input logic [31:0] pc, input logic h, input logic t,
                       input logic [31:0] tgt, input string nm);
    pred_pc = pc;
    exp_q.push_back({h, t, tgt});
    name_q.push_back(nm);
    pred_chk = 1'b1;
  endtask

  task automatic stats(input int br, input int mp, input int br4, input int mp4, input string nm);
    stat_q.push_back({32'(br), 32'(mp), 4'(br4), 4'(mp4)});
    stat_name_q.push_back(nm);
    stat_chk = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    pred_pc = 32'h0; upd_pc = 32'h0; upd_target = 32'h0;
    upd_is_jump = 1'b0; upd_taken = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0; stat_clr = 1'b0;

    // reset together with a taken update: table and stats stay untouched
    RESET = 1'b1; upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b1); tick();
    query(32'h40, 1'b0, 1'b0, 32'h44, "reset_query");
    stats(0, 0, 0, 0, "reset_stats"); tick();
    query(32'h100, 1'b0, 1'b0, 32'h104, "reset_blocks_update"); tick();

    // taken branch 0x100 -> 0x80: WT, then ST, then two not-takens to drop below taken
    upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b1); tick();
    query(32'h100, 1'b1, 1'b1, 32'h80, "alloc_wt");
    upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0); tick();
    upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0); tick();
    query(32'h100, 1'b1, 1'b1, 32'h80, "same_cycle_pre_update");
    upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    query(32'h100, 1'b1, 1'b0, 32'h104, "after_two_not_taken");
    stats(4, 2, 4, 2, "stats_4_2"); tick();

    // not-taken miss does not allocate; mispredict without upd_en is ignored
    upd(32'h200, 1'b0, 1'b0, 32'h0, 1'b0); tick();
    query(32'h200, 1'b0, 1'b0, 32'h204, "nt_miss_no_alloc");
    stats(5, 2, 5, 2, "stats_5_2");
    upd_mispredict = 1'b1; tick();

    // jump entry keeps predicting taken while its counter drains to zero
    upd(32'h30C, 1'b1, 1'b1, 32'h1000, 1'b0); tick();
    query(32'h30C, 1'b1, 1'b1, 32'h1000, "jump_alloc");
    stats(6, 2, 6, 2, "stray_mispredict_ignored");
    upd(32'h30C, 1'b1, 1'b0, 32'h0, 1'b0); tick();
    upd(32'h30C, 1'b1, 1'b0, 32'h0, 1'b0); tick();
    upd(32'h30C, 1'b1, 1'b0, 32'h0, 1'b0); tick();
    query(32'h30C, 1'b1, 1'b1, 32'h1000, "jump_always_taken"); tick();

    // aliasing on idx 1: 0x204 evicts 0x104
    upd(32'h104, 1'b0, 1'b1, 32'h500, 1'b0); tick();
    query(32'h104, 1'b1, 1'b1, 32'h500, "alias_first"); tick();
    upd(32'h204, 1'b0, 1'b1, 32'h600, 1'b0); tick();
    query(32'h104, 1'b0, 1'b0, 32'h108, "alias_evicted"); tick();
    query(32'h204, 1'b1, 1'b1, 32'h600, "alias_resident"); tick();

    // fall-through wrap-around and pc[1:0] ignored
    query(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, "target_wrap"); tick();
    query(32'h102, 1'b1, 1'b0, 32'h106, "low_bits_ignored");
    stats(11, 2, 11, 2, "stats_11_2"); tick();

    // stat_clr wins over same-cycle increment
    stat_clr = 1'b1; upd(32'h400, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    stats(0, 0, 0, 0, "clr_wins"); tick();

    // 20 mispredicted events: 32-bit counts 20, 4-bit counters saturate at 15
    for (int i = 0; i < 20; i++) begin
      upd(32'h400, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    end
    stats(20, 20, 15, 15, "stat_saturate"); tick();

    // mid-run reset clears the table and stats
    RESET = 1'b1; tick();
    query(32'h30C, 1'b0, 1'b0, 32'h310, "post_reset_query");
    stats(0, 0, 0, 0, "post_reset_stats"); tick();

    end_chk = 1'b1;
    @(negedge CLK);
    #1;
    end_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
